// File: rtl/sparc_exu_div_yreg_ctl.sv
// Y-register write-select control: WRY/MULScc pipelines, per-thread select priority and busy tracking.
// Optional build macro YREG_COLL_CHK_EN adds a sticky same-thread collision flag.
module sparc_exu_div_yreg_ctl (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       se,
  input  logic [3:0] ecl_thr_e,
  input  logic       wry_vld_e,
  input  logic       mulscc_vld_e,
  input  logic       byp_rs1_0_e,
  input  logic       kill_m,
  input  logic       flush_w,
  input  logic       mul_ywr_vld_g,
  input  logic [3:0] mul_thr_g,
  output logic [3:0] ecl_div_yreg_wen_w,
  output logic [3:0] ecl_div_yreg_wen_g,
  output logic [3:0] ecl_div_yreg_shift_g,
  output logic [3:0] ecl_div_yreg_wen_l,
  output logic       ecl_div_yreg_data_31_g,
  output logic [3:0] ecl_yreg_busy,
  output logic       ecl_yreg_coll_err
);

  logic       unused_se;
  logic       e_thr_any;
  logic       wry_e, mulscc_e;

  logic       wry_vld_m_q,  wry_vld_w_q,  wry_vld_w2_q;
  logic       wry_vld_w_d,  wry_vld_w2_d;
  logic [3:0] wry_thr_m_q,  wry_thr_w_q,  wry_thr_w2_q;

  logic       msc_vld_m_q,  msc_vld_w_q,  msc_vld_g_q;
  logic       msc_vld_w_d,  msc_vld_g_d;
  logic [3:0] msc_thr_m_q,  msc_thr_w_q,  msc_thr_g_q;
  logic       msc_rs1_m_q,  msc_rs1_w_q,  msc_rs1_g_q;

  logic [3:0] raw_wen_w, raw_wen_g, raw_shift;

  assign unused_se = se;

  // An all-zero thread select is dropped at E; WRY wins when both valids are set.
  assign e_thr_any = |ecl_thr_e;
  assign wry_e     = wry_vld_e & e_thr_any;
  assign mulscc_e  = mulscc_vld_e & ~wry_vld_e & e_thr_any;

  assign wry_vld_w_d  = wry_vld_m_q & ~kill_m;
  assign wry_vld_w2_d = wry_vld_w_q & ~flush_w;
  assign msc_vld_w_d  = msc_vld_m_q & ~kill_m;
  assign msc_vld_g_d  = msc_vld_w_q & ~flush_w;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wry_vld_m_q  <= 1'b0;
      wry_vld_w_q  <= 1'b0;
      wry_vld_w2_q <= 1'b0;
      wry_thr_m_q  <= 4'h0;
      wry_thr_w_q  <= 4'h0;
      wry_thr_w2_q <= 4'h0;
      msc_vld_m_q  <= 1'b0;
      msc_vld_w_q  <= 1'b0;
      msc_vld_g_q  <= 1'b0;
      msc_thr_m_q  <= 4'h0;
      msc_thr_w_q  <= 4'h0;
      msc_thr_g_q  <= 4'h0;
      msc_rs1_m_q  <= 1'b0;
      msc_rs1_w_q  <= 1'b0;
      msc_rs1_g_q  <= 1'b0;
    end else begin
      wry_vld_m_q  <= wry_e;
      wry_vld_w_q  <= wry_vld_w_d;
      wry_vld_w2_q <= wry_vld_w2_d;
      wry_thr_m_q  <= ecl_thr_e;
      wry_thr_w_q  <= wry_thr_m_q;
      wry_thr_w2_q <= wry_thr_w_q;
      msc_vld_m_q  <= mulscc_e;
      msc_vld_w_q  <= msc_vld_w_d;
      msc_vld_g_q  <= msc_vld_g_d;
      msc_thr_m_q  <= ecl_thr_e;
      msc_thr_w_q  <= msc_thr_m_q;
      msc_thr_g_q  <= msc_thr_w_q;
      msc_rs1_m_q  <= byp_rs1_0_e;
      msc_rs1_w_q  <= msc_rs1_m_q;
      msc_rs1_g_q  <= msc_rs1_w_q;
    end
  end

  // The multiplier request is gated by reset so every select idles while rst_l is low.
  assign raw_wen_w = {4{wry_vld_w2_q}} & wry_thr_w2_q;
  assign raw_wen_g = {4{mul_ywr_vld_g & rst_l}} & mul_thr_g;
  assign raw_shift = {4{msc_vld_g_q}} & msc_thr_g_q;

  // Priority is resolved per thread, so different threads never block each other.
  assign ecl_div_yreg_wen_w     = raw_wen_w;
  assign ecl_div_yreg_wen_g     = raw_wen_g & ~raw_wen_w;
  assign ecl_div_yreg_shift_g   = raw_shift & ~raw_wen_w & ~raw_wen_g;
  assign ecl_div_yreg_wen_l     = ~(ecl_div_yreg_wen_w | ecl_div_yreg_wen_g | ecl_div_yreg_shift_g);
  assign ecl_div_yreg_data_31_g = msc_rs1_g_q & (|ecl_div_yreg_shift_g);

  // Busy covers every stage holding a live instruction, so younger ones keep it set.
  assign ecl_yreg_busy = ({4{wry_vld_m_q}}  & wry_thr_m_q)
                       | ({4{wry_vld_w_q}}  & wry_thr_w_q)
                       | ({4{wry_vld_w2_q}} & wry_thr_w2_q)
                       | ({4{msc_vld_m_q}}  & msc_thr_m_q)
                       | ({4{msc_vld_w_q}}  & msc_thr_w_q)
                       | ({4{msc_vld_g_q}}  & msc_thr_g_q);

`ifdef YREG_COLL_CHK_EN
  logic       coll_err_q, coll_err_d;
  logic [3:0] coll_multi;

  assign coll_multi = (raw_wen_w & raw_wen_g) | (raw_wen_w & raw_shift) | (raw_wen_g & raw_shift);
  assign coll_err_d = coll_err_q | (|coll_multi);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) coll_err_q <= 1'b0;
    else        coll_err_q <= coll_err_d;
  end

  assign ecl_yreg_coll_err = coll_err_q;
`else
  assign ecl_yreg_coll_err = 1'b0;
`endif

endmodule

// File: tb/tb_sparc_exu_div_yreg_ctl.sv
// Bench for sparc_exu_div_yreg_ctl: vector table with scoreboard plus directed reset/younger-op sequences.
module tb_sparc_exu_div_yreg_ctl;

  logic       clk;
  logic       rst_l;
  logic       se;
  logic [3:0] ecl_thr_e;
  logic       wry_vld_e, mulscc_vld_e, byp_rs1_0_e;
  logic       kill_m, flush_w;
  logic       mul_ywr_vld_g;
  logic [3:0] mul_thr_g;
  logic [3:0] wen_w, wen_g, shift_g, wen_l, busy;
  logic       data_31_g, coll_err;

`ifdef YREG_COLL_CHK_EN
  localparam logic COLL_ON = 1'b1;
`else
  localparam logic COLL_ON = 1'b0;
`endif

  sparc_exu_div_yreg_ctl dut (
    .clk                    (clk),
    .rst_l                  (rst_l),
    .se                     (se),
    .ecl_thr_e              (ecl_thr_e),
    .wry_vld_e              (wry_vld_e),
    .mulscc_vld_e           (mulscc_vld_e),
    .byp_rs1_0_e            (byp_rs1_0_e),
    .kill_m                 (kill_m),
    .flush_w                (flush_w),
    .mul_ywr_vld_g          (mul_ywr_vld_g),
    .mul_thr_g              (mul_thr_g),
    .ecl_div_yreg_wen_w     (wen_w),
    .ecl_div_yreg_wen_g     (wen_g),
    .ecl_div_yreg_shift_g   (shift_g),
    .ecl_div_yreg_wen_l     (wen_l),
    .ecl_div_yreg_data_31_g (data_31_g),
    .ecl_yreg_busy          (busy),
    .ecl_yreg_coll_err      (coll_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wry, msc, rs1, kill1, flush2, mulv3;
    logic [3:0] thr, mthr3;
    logic [3:0] w, g, s, l;
    logic       d31;
    logic [3:0] b1, b2, b3, b4;
    logic       coll4;
  } vec_t;

  typedef struct packed {
    logic [3:0] w, g, s, l;
    logic       d31;
    logic [3:0] b1, b2, b3, b4;
    logic       coll4;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];

  int total = 0;
  int bad   = 0;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%b required=%b (t=%0t)", name, act, req, $time);
    end
  endtask

  // driver tasks
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    ecl_thr_e = 4'h0; wry_vld_e = 1'b0; mulscc_vld_e = 1'b0; byp_rs1_0_e = 1'b0;
    kill_m = 1'b0; flush_w = 1'b0; mul_ywr_vld_g = 1'b0; mul_thr_g = 4'h0;
  endtask

  task automatic do_reset;
    rst_l = 1'b0;
    clear_inputs();
    @(negedge clk);
    chk("rst_wen_l", wen_l, 4'hF);
    chk("rst_busy", busy, 4'h0);
    chk("rst_coll", {3'b0, coll_err}, 4'h0);
    next_cycle();
    rst_l = 1'b1;
  endtask

  function automatic vec_t mk(input logic wry, msc, input logic [3:0] thr, input logic rs1,
                              input logic kill1, flush2, mulv3, input logic [3:0] mthr3,
                              input logic [3:0] w, g, s, l, input logic d31,
                              input logic [3:0] b1, b2, b3, b4, input logic coll4);
    vec_t v;
    v.wry = wry; v.msc = msc; v.thr = thr; v.rs1 = rs1;
    v.kill1 = kill1; v.flush2 = flush2; v.mulv3 = mulv3; v.mthr3 = mthr3;
    v.w = w; v.g = g; v.s = s; v.l = l; v.d31 = d31;
    v.b1 = b1; v.b2 = b2; v.b3 = b3; v.b4 = b4; v.coll4 = coll4;
    return v;
  endfunction

  // One instruction at E in cycle 0; kill in 1, flush in 2, multiplier write in 3.
  task automatic run_vec(input vec_t v, input int idx);
    exp_t e, a;
    do_reset();
    wry_vld_e = v.wry; mulscc_vld_e = v.msc; ecl_thr_e = v.thr; byp_rs1_0_e = v.rs1;
    e.w = v.w; e.g = v.g; e.s = v.s; e.l = v.l; e.d31 = v.d31;
    e.b1 = v.b1; e.b2 = v.b2; e.b3 = v.b3; e.b4 = v.b4; e.coll4 = v.coll4;
    exp_q.push_back(e);
    @(negedge clk);
    chk($sformatf("v%0d_c0_wen_l", idx), wen_l, 4'hF);
    next_cycle();
    clear_inputs(); kill_m = v.kill1;
    @(negedge clk); a.b1 = busy;
    next_cycle();
    kill_m = 1'b0; flush_w = v.flush2;
    @(negedge clk); a.b2 = busy;
    next_cycle();
    flush_w = 1'b0; mul_ywr_vld_g = v.mulv3; mul_thr_g = v.mthr3;
    @(negedge clk);
    a.w = wen_w; a.g = wen_g; a.s = shift_g; a.l = wen_l; a.d31 = data_31_g; a.b3 = busy;
    next_cycle();
    mul_ywr_vld_g = 1'b0; mul_thr_g = 4'h0;
    @(negedge clk); a.b4 = busy; a.coll4 = coll_err;
    // scoreboard
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL v%0d_scoreboard actual=empty required=entry", idx);
    end else begin
      e = exp_t'(exp_q.pop_front());
      chk($sformatf("v%0d_wen_w", idx), a.w, e.w);
      chk($sformatf("v%0d_wen_g", idx), a.g, e.g);
      chk($sformatf("v%0d_shift_g", idx), a.s, e.s);
      chk($sformatf("v%0d_wen_l", idx), a.l, e.l);
      chk($sformatf("v%0d_data31", idx), {3'b0, a.d31}, {3'b0, e.d31});
      chk($sformatf("v%0d_busy1", idx), a.b1, e.b1);
      chk($sformatf("v%0d_busy2", idx), a.b2, e.b2);
      chk($sformatf("v%0d_busy3", idx), a.b3, e.b3);
      chk($sformatf("v%0d_busy4", idx), a.b4, e.b4);
      chk($sformatf("v%0d_coll", idx), {3'b0, a.coll4}, {3'b0, e.coll4});
    end
  endtask

  initial begin
    se = 1'b0;
    rst_l = 1'b0;
    clear_inputs();
    //         wry  msc  thr     rs1 k1 f2 mv3 mthr3    w        g        s        l        d31 b1       b2       b3       b4     coll
    vecs[0]  = mk(1, 0, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1101, 0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 0);
    vecs[1]  = mk(0, 1, 4'b0100, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1011, 1, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 0);
    vecs[2]  = mk(1, 0, 4'b0001, 0, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0);
    vecs[3]  = mk(1, 0, 4'b1000, 0, 0, 0, 1, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0111, 0, 4'b1000, 4'b1000, 4'b1000, 4'b0000, COLL_ON);
    vecs[4]  = mk(1, 0, 4'b0001, 0, 0, 0, 1, 4'b0100, 4'b0001, 4'b0100, 4'b0000, 4'b1010, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 0);
    vecs[5]  = mk(1, 1, 4'b0010, 1, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1101, 0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 0);
    vecs[6]  = mk(1, 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    vecs[7]  = mk(0, 1, 4'b0100, 1, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 0);
    vecs[8]  = mk(0, 1, 4'b0010, 1, 0, 0, 1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b1101, 0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, COLL_ON);
    vecs[9]  = mk(0, 1, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b1110, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 0);
    vecs[10] = mk(0, 0, 4'b0000, 0, 0, 0, 1, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0111, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Random different-thread pairs: WRY thread a at W2 alongside multiplier write to thread b.
    for (int i = 0; i < 6; i++) begin
      int a, b;
      logic [3:0] ta, tb;
      a = $urandom_range(0, 3);
      b = (a + $urandom_range(1, 3)) % 4;
      ta = 4'b0001 << a;
      tb = 4'b0001 << b;
      run_vec(mk(1, 0, ta, 1'($urandom_range(0, 1)), 0, 0, 1, tb,
                 ta, tb, 4'b0000, ~(ta | tb), 0, ta, ta, ta, 4'b0000, 0), 100 + i);
    end

    // Reset while a WRY sits in W: nothing must leak out after release.
    do_reset();
    wry_vld_e = 1'b1; ecl_thr_e = 4'b0100;
    next_cycle();
    clear_inputs();
    next_cycle();
    rst_l = 1'b0;
    mul_ywr_vld_g = 1'b1; mul_thr_g = 4'b0010;
    @(negedge clk);
    chk("rstw_wen_l", wen_l, 4'hF);
    chk("rstw_wen_g", wen_g, 4'h0);
    chk("rstw_busy", busy, 4'h0);
    next_cycle();
    @(negedge clk);
    chk("rstw_wen_w", wen_w, 4'h0);
    next_cycle();
    rst_l = 1'b1;
    clear_inputs();
    wry_vld_e = 1'b1; ecl_thr_e = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rel_c%0d_wen_w", c), wen_w, (c == 3) ? 4'b0010 : 4'b0000);
      next_cycle();
      clear_inputs();
    end

    // Younger MULScc keeps busy set past the older WRY's write.
    do_reset();
    wry_vld_e = 1'b1; ecl_thr_e = 4'b0001;
    next_cycle();
    clear_inputs();
    mulscc_vld_e = 1'b1; ecl_thr_e = 4'b0001; byp_rs1_0_e = 1'b1;
    next_cycle();
    clear_inputs();
    next_cycle();
    @(negedge clk);
    chk("yng_c3_wen_w", wen_w, 4'b0001);
    chk("yng_c3_shift", shift_g, 4'b0000);
    next_cycle();
    @(negedge clk);
    chk("yng_c4_shift", shift_g, 4'b0001);
    chk("yng_c4_data31", {3'b0, data_31_g}, 4'b0001);
    chk("yng_c4_busy", busy, 4'b0001);
    next_cycle();
    @(negedge clk);
    chk("yng_c5_busy", busy, 4'b0000);
    chk("yng_c5_wen_l", wen_l, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
